// File: rtl/f1_reaction_monitor.sv
// f1_reaction_monitor
//   Receiving end of the F1 start-light interface. Checks that the 8-bit
//   thermometer light bar advances legally (hold or one-light step), detects
//   lights-out after the full bar, then times the driver's button press.
//   One result per start (reaction time, jump start or timeout) leaves through
//   a valid/ready handshake; protocol violations park the block in FAULT until
//   fault_clr.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   lights[7:0]   light bar from the sequencer
//   btn           driver button (level, synchronous to clk)
//   result_ready  consumer accepts the result when high with result_valid
//   fault_clr     leaves FAULT, back to SYNC
//   result_valid  result registers hold a valid result
//   react_time    cycles from lights-out to press; all-ones on timeout, 0 on jump start
//   jump_start    result qualifier: press before lights-out
//   timeout       result qualifier: counter saturated without a press
//   fault         high while in FAULT
//   armed         high in ARMING, FULL and TIMING
module f1_reaction_monitor #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       lights,
    input  logic             btn,
    input  logic             result_ready,
    input  logic             fault_clr,
    output logic             result_valid,
    output logic [CNT_W-1:0] react_time,
    output logic             jump_start,
    output logic             timeout,
    output logic             fault,
    output logic             armed
);

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ARMING = 3'd2,
        ST_FULL   = 3'd3,
        ST_TIMING = 3'd4,
        ST_DONE   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    state_t           state;
    logic [7:0]       prev;
    logic             btn_q;
    logic [CNT_W-1:0] count;
    logic             btn_edge;
    logic             legal_step;

    assign btn_edge = btn & ~btn_q;

    // A gated sequencer may hold a pattern, so hold is as legal as a single step.
    assign legal_step = (lights == prev) || (lights == {prev[6:0], 1'b1});

    always_comb begin
        armed = (state == ST_ARMING) || (state == ST_FULL) || (state == ST_TIMING);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_SYNC;
            prev         <= '0;
            btn_q        <= 1'b0;
            count        <= '0;
            result_valid <= 1'b0;
            react_time   <= '0;
            jump_start   <= 1'b0;
            timeout      <= 1'b0;
            fault        <= 1'b0;
        end else begin
            btn_q <= btn;
            prev  <= lights;
            case (state)
                ST_SYNC: begin
                    if (lights == 8'h00)
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (lights == 8'h01) begin
                        state <= ST_ARMING;
                    end else if (lights != 8'h00) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end
                end
                ST_ARMING: begin
                    // A press outranks any lights check in the same cycle.
                    if (btn_edge) begin
                        state        <= ST_DONE;
                        result_valid <= 1'b1;
                        jump_start   <= 1'b1;
                        react_time   <= '0;
                    end else if (!legal_step) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end else if (lights == 8'hFF) begin
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // A press in the cycle lights-out is first seen is still a jump start.
                    if (btn_edge) begin
                        state        <= ST_DONE;
                        result_valid <= 1'b1;
                        jump_start   <= 1'b1;
                        react_time   <= '0;
                    end else if (lights == 8'h00) begin
                        state <= ST_TIMING;
                        count <= '0;
                    end else if (lights != 8'hFF) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end
                end
                ST_TIMING: begin
                    // Lights are ignored here: the sequencer may already restart at 01.
                    if (btn_edge) begin
                        state        <= ST_DONE;
                        result_valid <= 1'b1;
                        react_time   <= count;
                    end else if (count == '1) begin
                        state        <= ST_DONE;
                        result_valid <= 1'b1;
                        timeout      <= 1'b1;
                        react_time   <= '1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state        <= ST_SYNC;
                        result_valid <= 1'b0;
                        jump_start   <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state <= ST_SYNC;
                        fault <= 1'b0;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_f1_reaction_monitor.sv
module tb_f1_reaction_monitor;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    lights = '0;
    logic          btn = 1'b0;
    logic          result_ready = 1'b0;
    logic          fault_clr = 1'b0;
    logic          result_valid;
    logic [CW-1:0] react_time;
    logic          jump_start;
    logic          timeout;
    logic          fault;
    logic          armed;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    f1_reaction_monitor #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .lights       (lights),
        .btn          (btn),
        .result_ready (result_ready),
        .fault_clr    (fault_clr),
        .result_valid (result_valid),
        .react_time   (react_time),
        .jump_start   (jump_start),
        .timeout      (timeout),
        .fault        (fault),
        .armed        (armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    l;
        logic          b;
        logic          r;
        logic          c;
        logic          vl;
        logic [CW-1:0] t;
        logic          j;
        logic          to;
        logic          f;
        logic          a;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] l, input logic b, input logic r, input logic c,
                                input logic vl, input logic [CW-1:0] t, input logic j,
                                input logic to, input logic f, input logic a);
        vec_t v;
        v.l = l; v.b = b; v.r = r; v.c = c;
        v.vl = vl; v.t = t; v.j = j; v.to = to; v.f = f; v.a = a;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h, expected %0h at %0t", name, idx, got, exp, $time);
        end
    endtask

    // Apply inputs at a falling edge; return at the next falling edge with outputs settled.
    task automatic drive(input logic [7:0] l, input logic b, input logic r, input logic c);
        lights = l; btn = b; result_ready = r; fault_clr = c;
        @(negedge clk);
    endtask

    task automatic chk_all(input string name, input int idx, input logic vl, input logic [CW-1:0] t,
                           input logic j, input logic to, input logic f, input logic a);
        chk({name, ".valid"}, idx, result_valid, vl);
        chk({name, ".time"},  idx, react_time, t);
        chk({name, ".jump"},  idx, jump_start, j);
        chk({name, ".tmo"},   idx, timeout, to);
        chk({name, ".fault"}, idx, fault, f);
        chk({name, ".armed"}, idx, armed, a);
    endtask

    logic [7:0] pats [9];

    // 00 then the full bar then lights-out: ends with the DUT in TIMING, count 0.
    task automatic run_to_timing();
        for (int i = 0; i < 9; i++) drive(pats[i], 1'b0, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        pats = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

        // A: clean start, press seen in TIMING cycle 5
        vecs.push_back(mk(8'h00,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(8'h01,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h03,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h07,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h0F,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h1F,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h3F,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h7F,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'hFF,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'hFF,0,0,0, 0,0,0,0,0,1));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(8'h00,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h00,1,0,0, 1,5,0,0,0,0));
        vecs.push_back(mk(8'h00,1,0,0, 1,5,0,0,0,0));
        vecs.push_back(mk(8'h00,0,1,0, 0,5,0,0,0,0));
        // B: jump start at 0F, consumer stalls three cycles
        vecs.push_back(mk(8'h00,0,0,0, 0,5,0,0,0,0));
        vecs.push_back(mk(8'h01,0,0,0, 0,5,0,0,0,1));
        vecs.push_back(mk(8'h03,0,0,0, 0,5,0,0,0,1));
        vecs.push_back(mk(8'h07,0,0,0, 0,5,0,0,0,1));
        vecs.push_back(mk(8'h0F,1,0,0, 1,0,1,0,0,0));
        vecs.push_back(mk(8'h1F,1,0,0, 1,0,1,0,0,0));
        vecs.push_back(mk(8'h3F,1,0,0, 1,0,1,0,0,0));
        vecs.push_back(mk(8'h7F,1,0,0, 1,0,1,0,0,0));
        vecs.push_back(mk(8'hFF,0,1,0, 0,0,0,0,0,0));
        vecs.push_back(mk(8'hFF,0,0,0, 0,0,0,0,0,0));
        // C: illegal 03->0F, clear, then a legal start timed at 2 (lights ignored in TIMING)
        vecs.push_back(mk(8'h00,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(8'h01,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h03,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h0F,0,0,0, 0,0,0,0,1,0));
        vecs.push_back(mk(8'h1F,0,0,0, 0,0,0,0,1,0));
        vecs.push_back(mk(8'h00,0,0,1, 0,0,0,0,0,0));
        vecs.push_back(mk(8'h00,0,0,0, 0,0,0,0,0,0));
        for (int i = 1; i < 9; i++) vecs.push_back(mk(pats[i],0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h00,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h01,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h00,0,0,0, 0,0,0,0,0,1));
        vecs.push_back(mk(8'h00,1,0,0, 1,2,0,0,0,0));
        vecs.push_back(mk(8'h00,1,1,0, 0,2,0,0,0,0));

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].l, vecs[i].b, vecs[i].r, vecs[i].c);
            chk_all("vec", i, vecs[i].vl, vecs[i].t, vecs[i].j, vecs[i].to, vecs[i].f, vecs[i].a);
        end

        // D: every pattern held 4 cycles, press coincident with lights-out
        for (int p = 0; p < 9; p++) begin
            for (int k = 0; k < 4; k++) begin
                drive(pats[p], 1'b0, 1'b0, 1'b0);
                chk("slow.fault", p, fault, 1'b0);
            end
        end
        chk("slow.full_armed", 0, armed, 1'b1);
        drive(8'h00, 1'b1, 1'b0, 1'b0);
        chk_all("slow.jump", 0, 1, 0, 1, 0, 0, 0);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        chk("slow.accept", 0, result_valid, 1'b0);

        // E: no press, counter saturates at 4'hF
        run_to_timing();
        for (int i = 1; i <= 15; i++) begin
            drive(8'h00, 1'b0, 1'b0, 1'b0);
            chk("tmo.pending", i, result_valid, 1'b0);
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk_all("tmo.done", 0, 1, 4'hF, 0, 1, 0, 0);

        // Reset while a result is pending drops it without a clock edge
        #2 rst = 1'b0;
        #1 chk_all("rst_done", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // F: reset in TIMING at count 7, release with 03 on the bar
        run_to_timing();
        for (int i = 0; i < 7; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_tim.armed_before", 0, armed, 1'b1);
        #2 begin rst = 1'b0; lights = 8'h03; end
        #1 chk_all("rst_tim", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(8'h03, 1'b0, 1'b0, 1'b0);
            chk_all("sync_wait", i, 0, 0, 0, 0, 0, 0);
        end
        drive(8'h01, 1'b0, 1'b0, 1'b0);
        chk_all("sync_01", 0, 0, 0, 0, 0, 0, 0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk("sync_00.armed", 0, armed, 1'b0);
        drive(8'h01, 1'b0, 1'b0, 1'b0);
        chk_all("resume", 0, 0, 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/f1_reaction_monitor.md
Name: f1_reaction_monitor

Overview:
- Receiving end of the F1 start-light interface. Watches the 8-bit thermometer light bar produced by the light-sequence FSM and checks that the sequence is legal.
- Detects "lights out" after the full bar, then times the driver's button press from that moment.
- Reports one of: reaction time, jump start, timeout or protocol fault. Results leave through a valid/ready handshake to the display/scoring logic.

Parameters:
CNT_W, 16, width of reaction counter and react_time; counter saturates at 2^CNT_W-1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low (rst=0 resets)
lights  input  8  light bar from sequencer: legal values 00,01,03,07,0F,1F,3F,7F,FF
btn  input  1  driver button, synchronous to clk, level
result_ready  input  1  consumer accepts result when high with result_valid
fault_clr  input  1  clears FAULT state
result_valid  output  1  result registers valid
react_time  output  CNT_W  cycles from lights-out to press; all-ones on timeout; 0 on jump start
jump_start  output  1  qualifies result: button pressed before lights out
timeout  output  1  qualifies result: counter saturated without press
fault  output  1  high while in FAULT
armed  output  1  high in ARMING, FULL, TIMING

Behaviour:
- Reset (rst=0, async): state=SYNC; result_valid=0, react_time=0, jump_start=0, timeout=0, fault=0, armed=0; count=0, btn_q=0.
- btn_edge = btn & ~btn_q. btn_q is registered every cycle. Only rising edges count.
- lights is sampled each cycle and held values are legal, because the sequencer may be gated by its enable.
- Legal step from prev pattern p: lights==p (hold) or lights=={p[6:0],1'b1}. prev is a registered copy of lights.
- SYNC: wait for lights==00, then go to IDLE. Any other value: stay in SYNC, no fault.
- IDLE:
  - lights==00: stay.
  - lights==01: go to ARMING.
  - Any other value: go to FAULT.
  - btn ignored.
- ARMING:
  - Legal hold or step: stay.
  - Step to FF: go to FULL.
  - Illegal value (skip, decrease, non-thermometer, early 00): go to FAULT.
  - btn_edge: go to DONE with jump_start=1, react_time=0. btn_edge has priority over the lights check in the same cycle.
- FULL:
  - lights==FF: stay.
  - lights==00: go to TIMING, count<=0.
  - Any other value: go to FAULT.
  - btn_edge: jump start. This includes the cycle where lights==00 is first sampled, so a press coincident with lights-out is a jump start.
- TIMING:
  - lights ignored, because the sequencer may restart at 01.
  - No btn_edge: count<=count+1.
  - btn_edge: go to DONE with react_time<=count, so a press in the first TIMING cycle gives 0.
  - count==2^CNT_W-1 with no press: go to DONE with timeout=1, react_time=all-ones.
- DONE:
  - result_valid=1. react_time, jump_start and timeout are stable until accepted.
  - result_valid && result_ready: clear result_valid, jump_start and timeout, go to SYNC. react_time holds its last value.
  - btn and lights ignored.
- FAULT:
  - fault=1.
  - fault_clr: go to SYNC.
  - Everything else ignored. No result is produced.
- Latency: result_valid rises on the cycle after the deciding event (registered outputs).
- armed is combinational from the state register.
- Reset mid-operation aborts any pending result; result_valid drops immediately.
- State encoding: 3 bits; unreachable codes go to SYNC.

Test Plan:
- Sequencer en=1 runs 00,01,03..FF,00. btn rises 5 cycles after the first 00 is sampled in FULL -> result_valid=1 next cycle, react_time=5, jump_start=0, timeout=0.
- Same sequence, btn rises while lights==0F -> DONE with jump_start=1, react_time=0. Hold result_ready=0 for 3 cycles: outputs stable. Pulse ready -> result_valid=0, state SYNC.
- Sequence with each pattern held 4 cycles (en duty 1/4) -> no fault, FULL reached. btn edge on the same cycle 00 is first seen -> jump_start=1.
- CNT_W=4, no press after lights out -> after 15 TIMING cycles result_valid=1, timeout=1, react_time=4'hF.
- Illegal step 03->0F -> fault=1, armed=0, no result_valid. fault_clr=1 then lights=00 -> back to IDLE; a following legal sequence times correctly.
- Assert rst=0 in TIMING with count=7 -> all outputs 0 at once. Release with lights=03 -> stays in SYNC until 00 is seen.
